// File: rtl/rv_trace_pkg.sv
// Shared types for the retire trace port: record layout, serializer states,
// header field positions and the packet word-sequencing helpers.
package rv_trace_pkg;

    localparam int DROP_W            = 11;
    localparam logic [DROP_W-1:0] DROP_MAX = 11'd2047;

    localparam int HDR_SEQ_LSB       = 24;
    localparam int HDR_OVF_BIT       = 23;
    localparam int HDR_REG_WRITE_BIT = 22;
    localparam int HDR_MEM_READ_BIT  = 21;
    localparam int HDR_MEM_WRITE_BIT = 20;
    localparam int HDR_SEL_LSB       = 16;
    localparam int HDR_RD_LSB        = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PC,
        ST_INSTR,
        ST_RD,
        ST_ADDR,
        ST_DATA
    } trace_state_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } trace_flags_t;

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       instr;
        logic [31:0]       rd_data;
        logic [31:0]       mem_addr;
        logic [31:0]       mem_data;
        logic [3:0]        sel;
        trace_flags_t      flags;
        logic [7:0]        seq;
        logic [DROP_W-1:0] drop_cnt;
    } trace_rec_t;

    // Word that follows s in a packet; ST_IDLE means s was the final word.
    function automatic trace_state_e next_word(trace_state_e s, trace_flags_t f);
        logic mem;
        mem = f.mem_read | f.mem_write;
        case (s)
            ST_HDR:   return ST_PC;
            ST_PC:    return ST_INSTR;
            ST_INSTR: return f.reg_write ? ST_RD : (mem ? ST_ADDR : ST_IDLE);
            ST_RD:    return mem ? ST_ADDR : ST_IDLE;
            ST_ADDR:  return ST_DATA;
            default:  return ST_IDLE;
        endcase
    endfunction

    function automatic logic [31:0] make_header(trace_rec_t r);
        logic [31:0] h;
        h = '0;
        h[HDR_SEQ_LSB +: 8]    = r.seq;
        h[HDR_OVF_BIT]         = (r.drop_cnt != '0);
        h[HDR_REG_WRITE_BIT]   = r.flags.reg_write;
        h[HDR_MEM_READ_BIT]    = r.flags.mem_read;
        h[HDR_MEM_WRITE_BIT]   = r.flags.mem_write;
        h[HDR_SEL_LSB +: 4]    = r.sel;
        h[HDR_RD_LSB +: 5]     = r.instr[11:7];
        h[DROP_W-1:0]          = r.drop_cnt;
        return h;
    endfunction

endpackage

// File: rtl/rv_trace_if.sv
// Valid/ready word stream from the trace port to the off-core trace sink.
interface rv_trace_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/rv_trace_fifo.sv
// Record FIFO with count-based occupancy; a push while full is taken only
// when a pop frees the slot in the same cycle.
module rv_trace_fifo
    import rv_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  trace_rec_t din,
    output trace_rec_t head,
    output logic       full,
    output logic       empty,
    output logic       one_left
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    trace_rec_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign one_left = (count == (AW+1)'(1));
    assign head     = mem[rd_ptr];

    // NOTE: storage is not reset; only the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rv_retire_trace_port.sv
// Retire trace port: captures one record per retired instruction, queues it,
// and serializes each record as a 3..6 word packet on the trace stream.
module rv_retire_trace_port
    import rv_trace_pkg::*;
#(
    parameter int IADDR_SPACE_BITS = 32,
    parameter int DEPTH            = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          retire,
    input  logic [IADDR_SPACE_BITS-1:1]   pc,
    input  logic [31:0]                   instr,
    input  logic                          reg_write,
    input  logic [31:0]                   rd_data,
    input  logic                          mem_read,
    input  logic                          mem_write,
    input  logic [31:0]                   mem_addr,
    input  logic [31:0]                   mem_data,
    input  logic [3:0]                    mem_sel,
    rv_trace_if.master                    stream,
    output logic                          empty,
    output logic                          full
);
    logic              retire_evt;
    logic              push;
    logic              pop;
    logic              one_left;
    logic [7:0]        seq;
    logic [DROP_W-1:0] drop_cnt;
    trace_rec_t        rec_in;
    trace_rec_t        head;
    trace_state_e      state;
    trace_state_e      after;

    assign retire_evt = retire & enable;
    assign pop        = stream.tvalid & stream.tready & stream.tlast;
    assign push       = retire_evt & (~full | pop);
    assign after      = next_word(state, head.flags);

    always_comb begin
        rec_in                 = '0;
        rec_in.pc              = 32'({pc, 1'b0});
        rec_in.instr           = instr;
        rec_in.rd_data         = rd_data;
        rec_in.mem_addr        = mem_addr;
        rec_in.mem_data        = mem_data;
        rec_in.sel             = mem_sel;
        rec_in.flags.reg_write = reg_write;
        rec_in.flags.mem_read  = mem_read;
        rec_in.flags.mem_write = mem_write;
        rec_in.seq             = seq;
        rec_in.drop_cnt        = drop_cnt;
    end

    rv_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .din      (rec_in),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .one_left (one_left)
    );

    // Seq advances on every retire event, dropped or not; drops saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq      <= '0;
            drop_cnt <= '0;
        end else if (retire_evt) begin
            seq <= seq + 8'd1;
            if (push)                      drop_cnt <= '0;
            else if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + DROP_W'(1);
        end
    end

    // IDLE->HDR on the same edge as the first push gives the one-cycle latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            stream.tvalid <= 1'b0;
            stream.tlast  <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (push || !empty) begin
                state         <= ST_HDR;
                stream.tvalid <= 1'b1;
            end
            stream.tlast <= 1'b0;
        end else if (stream.tready) begin
            if (stream.tlast) begin
                if (push || !one_left) begin
                    state         <= ST_HDR;
                    stream.tvalid <= 1'b1;
                end else begin
                    state         <= ST_IDLE;
                    stream.tvalid <= 1'b0;
                end
                stream.tlast <= 1'b0;
            end else begin
                state        <= after;
                stream.tlast <= (next_word(after, head.flags) == ST_IDLE);
            end
        end
    end

    always_comb begin
        case (state)
            ST_HDR:   stream.tdata = make_header(head);
            ST_PC:    stream.tdata = head.pc;
            ST_INSTR: stream.tdata = head.instr;
            ST_RD:    stream.tdata = head.rd_data;
            ST_ADDR:  stream.tdata = head.mem_addr;
            ST_DATA:  stream.tdata = head.mem_data;
            default:  stream.tdata = '0;
        endcase
    end

endmodule

// File: tb/tb_rv_retire_trace_port.sv
// Directed + randomized bench for rv_retire_trace_port with a packet-level
// scoreboard built from the retire inputs.
module tb_rv_retire_trace_port;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        retire;
    logic [31:1] pc;
    logic [31:0] instr;
    logic        reg_write;
    logic [31:0] rd_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_sel;
    logic        empty;
    logic        full;

    rv_trace_if stream ();

    always #5 clk = ~clk;

    rv_retire_trace_port #(.IADDR_SPACE_BITS(32), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .retire    (retire),
        .pc        (pc),
        .instr     (instr),
        .reg_write (reg_write),
        .rd_data   (rd_data),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_sel   (mem_sel),
        .stream    (stream),
        .empty     (empty),
        .full      (full)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: expected word stream plus record occupancy.
    logic [31:0] exp_words [$];
    bit          exp_last  [$];
    bit          exp_hdr   [$];
    int          outstanding;
    int          seq_m;
    int          drop_m;

    bit          prev_hold;
    logic [31:0] prev_data;
    logic        prev_last;
    int          last_hdr_seq;
    bit          wrap_seen;

    logic [31:0] t1w [4];
    logic [31:0] t2w [5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_pc(input logic [31:0] a);
        pc = a[31:1];
    endtask

    task automatic model_push_record();
        logic [31:0] w [$];
        logic [31:0] hdr;
        hdr = {seq_m[7:0], (drop_m != 0), reg_write, mem_read, mem_write,
               mem_sel, instr[11:7], drop_m[10:0]};
        w.push_back(hdr);
        w.push_back({pc, 1'b0});
        w.push_back(instr);
        if (reg_write) w.push_back(rd_data);
        if (mem_read || mem_write) begin
            w.push_back(mem_addr);
            w.push_back(mem_data);
        end
        for (int i = 0; i < w.size(); i++) begin
            exp_words.push_back(w[i]);
            exp_last.push_back(i == w.size() - 1);
            exp_hdr.push_back(i == 0);
        end
    endtask

    // One clock: compare outputs, apply handshake/retire to the model, advance.
    task automatic tick();
        int s;
        chk("tvalid", {31'd0, stream.tvalid}, {31'd0, outstanding != 0});
        chk("empty",  {31'd0, empty}, {31'd0, outstanding == 0});
        chk("full",   {31'd0, full},  {31'd0, outstanding == DEPTH});
        if (prev_hold) begin
            chk("hold_tdata", stream.tdata, prev_data);
            chk("hold_tlast", {31'd0, stream.tlast}, {31'd0, prev_last});
        end
        if (outstanding != 0) begin
            if (exp_words.size() == 0) begin
                chk("scoreboard_underrun", 32'd0, 32'd1);
            end else begin
                chk("tdata", stream.tdata, exp_words[0]);
                chk("tlast", {31'd0, stream.tlast}, {31'd0, exp_last[0]});
                if (stream.tready) begin
                    if (exp_hdr[0]) begin
                        s = int'(stream.tdata[31:24]);
                        if (last_hdr_seq == 255 && s == 0) wrap_seen = 1'b1;
                        last_hdr_seq = s;
                    end
                    if (exp_last[0]) outstanding--;
                    void'(exp_words.pop_front());
                    void'(exp_last.pop_front());
                    void'(exp_hdr.pop_front());
                end
            end
        end
        prev_hold = stream.tvalid && !stream.tready;
        prev_data = stream.tdata;
        prev_last = stream.tlast;
        if (retire && enable) begin
            if (outstanding < DEPTH) begin
                model_push_record();
                outstanding++;
                drop_m = 0;
            end else if (drop_m < 2047) begin
                drop_m++;
            end
            seq_m = (seq_m + 1) % 256;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        enable    = 1'b1;
        retire    = 1'b0;
        pc        = '0;
        instr     = '0;
        reg_write = 1'b0;
        rd_data   = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        mem_sel   = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        stream.tready = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_tvalid", {31'd0, stream.tvalid}, 32'd0);
        chk("rst_tlast",  {31'd0, stream.tlast},  32'd0);
        chk("rst_tdata",  stream.tdata, 32'd0);
        chk("rst_empty",  {31'd0, empty}, 32'd1);
        chk("rst_full",   {31'd0, full},  32'd0);
        exp_words.delete();
        exp_last.delete();
        exp_hdr.delete();
        outstanding  = 0;
        seq_m        = 0;
        drop_m       = 0;
        prev_hold    = 1'b0;
        last_hdr_seq = -1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_record();
        int r;
        set_pc($urandom());
        instr     = $urandom();
        rd_data   = $urandom();
        mem_addr  = $urandom();
        mem_data  = $urandom();
        mem_sel   = 4'($urandom());
        reg_write = 1'($urandom());
        r         = int'($urandom_range(0, 3));
        mem_read  = r[0];
        mem_write = r[1];
    endtask

    task automatic drain(input int budget);
        retire        = 1'b0;
        stream.tready = 1'b1;
        for (int i = 0; i < budget && outstanding != 0; i++) tick();
        chk("drain_done", outstanding, 32'd0);
    endtask

    initial begin
        t1w = '{32'h0040_0800, 32'h0000_0100, 32'h0050_0093, 32'h0000_0005};
        t2w = '{32'h011F_0000, 32'h0000_0104, 32'h0011_2023, 32'h0000_2000, 32'hDEAD_BEEF};
        wrap_seen = 1'b0;
        rst = 1'b1;
        clear_inputs();
        stream.tready = 1'b0;
        do_reset();

        // addi x1, x0, 5 at 0x100: four words, one-cycle latency
        stream.tready = 1'b1;
        retire    = 1'b1;
        set_pc(32'h100);
        instr     = 32'h0050_0093;
        reg_write = 1'b1;
        rd_data   = 32'd5;
        tick();
        retire    = 1'b0;
        reg_write = 1'b0;
        chk("t1_latency", {31'd0, stream.tvalid}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_word%0d", i), stream.tdata, t1w[i]);
            chk($sformatf("t1_last%0d", i), {31'd0, stream.tlast}, {31'd0, i == 3});
            tick();
        end
        chk("t1_idle_after", {31'd0, stream.tvalid}, 32'd0);

        // sw: five words, no rd word
        retire    = 1'b1;
        set_pc(32'h104);
        instr     = 32'h0011_2023;
        mem_write = 1'b1;
        mem_addr  = 32'h0000_2000;
        mem_data  = 32'hDEAD_BEEF;
        mem_sel   = 4'hF;
        tick();
        retire    = 1'b0;
        mem_write = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_word%0d", i), stream.tdata, t2w[i]);
            chk($sformatf("t2_last%0d", i), {31'd0, stream.tlast}, {31'd0, i == 4});
            tick();
        end

        // overflow: 10 retires into a stalled sink
        stream.tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            retire = 1'b1;
            rand_record();
            tick();
        end
        retire = 1'b0;
        chk("t3_full", {31'd0, full}, 32'd1);
        drain(200);
        retire    = 1'b1;
        rand_record();
        reg_write = 1'b1;
        tick();
        retire = 1'b0;
        chk("t3_seq",  {24'd0, stream.tdata[31:24]}, 32'd12);
        chk("t3_ovf",  {31'd0, stream.tdata[23]}, 32'd1);
        chk("t3_drop", {21'd0, stream.tdata[10:0]}, 32'd2);
        drain(50);

        // random retires, enables and sink backpressure
        for (int i = 0; i < 400; i++) begin
            retire        = ($urandom_range(0, 2) == 0);
            enable        = ($urandom_range(0, 9) != 0);
            stream.tready = 1'($urandom());
            rand_record();
            tick();
        end
        enable = 1'b1;
        drain(2000);

        // seq wrap, with disabled retires interleaved
        do_reset();
        stream.tready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rand_record();
            reg_write = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            retire    = 1'b1;
            enable    = 1'b1;
            tick();
            enable    = 1'b0;
            tick();
            retire    = 1'b0;
            enable    = 1'b1;
            tick();
            tick();
        end
        drain(100);
        chk("t5_wrap_seen", {31'd0, wrap_seen}, 32'd1);

        // reset after the PC word of a packet
        retire    = 1'b1;
        rand_record();
        reg_write = 1'b1;
        tick();
        retire = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("t6_async_tvalid", {31'd0, stream.tvalid}, 32'd0);
        do_reset();
        stream.tready = 1'b1;
        retire = 1'b1;
        rand_record();
        tick();
        retire = 1'b0;
        chk("t6_seq0", {24'd0, stream.tdata[31:24]}, 32'd0);
        drain(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
